// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one pipelined fadd among N requesters.
// Define FADD_ARB_SUB_EN to add the per-requester req_sub (x1 - x2) port.
module fadd_arbiter #(
  parameter  int N     = 4,
  parameter  int LAT   = 2,
  parameter  int DEPTH = 4,
  localparam int IDW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_x1,
  input  logic [32*N-1:0]   req_x2,
`ifdef FADD_ARB_SUB_EN
  input  logic [N-1:0]      req_sub,
`endif
  output logic [31:0]       fa_x1,
  output logic [31:0]       fa_x2,
  input  logic [31:0]       fa_y,
  input  logic              fa_ovf,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_y,
  output logic              resp_ovf,
  output logic [IDW-1:0]    resp_id
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = CW + 1;

  logic [IDW-1:0] rr;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx;
  logic           found;
  logic           credit;
  logic           issue;

  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];
  logic [UW-1:0]  in_flight;
  logic [UW-1:0]  used;

  logic [31:0]    mem_y   [DEPTH];
  logic           mem_ovf [DEPTH];
  logic [IDW-1:0] mem_id  [DEPTH];
  logic [AW-1:0]  wr;
  logic [AW-1:0]  rd;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  // first valid requester at or after rr, modulo N
  always_comb begin
    win   = rr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N))
        idx = idx - (IDW+1)'(N);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LAT; i++)
      in_flight = in_flight + UW'(tag_v[i]);
  end

  assign used      = UW'(count) + in_flight;
  assign credit    = used < UW'(DEPTH);
  assign issue     = found && credit && rstn;
  assign req_ready = issue ? (N'(1) << win) : '0;

  always_comb begin
    fa_x1 = '0;
    fa_x2 = '0;
    if (issue) begin
      fa_x1 = req_x1[{win, 5'b0} +: 32];
      fa_x2 = req_x2[{win, 5'b0} +: 32];
`ifdef FADD_ARB_SUB_EN
      fa_x2[31] = fa_x2[31] ^ req_sub[win];
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rr <= '0;
    else if (issue)
      rr <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
  end

  // tags ride alongside the non-stallable adder pipe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v <= '0;
      for (int i = 0; i < LAT; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= win;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign push       = tag_v[LAT-1];
  assign resp_valid = count != '0;
  assign pop        = resp_valid && resp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_y[i]   <= '0;
        mem_ovf[i] <= 1'b0;
        mem_id[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_y[wr]   <= fa_y;
        mem_ovf[wr] <= fa_ovf;
        mem_id[wr]  <= tag_id[LAT-1];
        wr          <= wr + 1'b1;
      end
      if (pop)
        rd <= rd + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign resp_y   = mem_y[rd];
  assign resp_ovf = mem_ovf[rd];
  assign resp_id  = mem_id[rd];

endmodule
